// File: rtl/mac_vec_acc_if.sv
// Bundles the job-control, operand-beat and result signals of the
// vector multiply-accumulate block into one parameterised interface.
interface mac_vec_acc_if #(
    parameter int DW    = 8,
    parameter int LANES = 4,
    parameter int ACCW  = 32,
    parameter int LENW  = 8
);
    logic                  start;
    logic [LENW-1:0]       len;
    logic                  signed_mode;
    logic                  sat_en;
    logic [LANES*DW-1:0]   din_a;
    logic [LANES*DW-1:0]   din_b;
    logic                  in_valid;
    logic                  in_ready;
    logic                  busy;
    logic                  done;
    logic [ACCW-1:0]       dout;
    logic                  overflow;

    modport master (
        output start, len, signed_mode, sat_en, din_a, din_b, in_valid,
        input  in_ready, busy, done, dout, overflow
    );

    modport slave (
        input  start, len, signed_mode, sat_en, din_a, din_b, in_valid,
        output in_ready, busy, done, dout, overflow
    );
endinterface

// File: rtl/mac_vec_acc.sv
// Vector multiply-accumulate: each accepted beat multiplies LANES operand
// pairs, sums the products and adds the sum into a wrapping or saturating
// accumulator. Three-stage pipeline (products, lane sum, accumulate), so the
// result settles two cycles after the last beat is accepted.
module mac_vec_acc #(
    parameter int DW    = 8,
    parameter int LANES = 4,
    parameter int ACCW  = 32,
    parameter int LENW  = 8
) (
    input  logic         clk,
    input  logic         rst,
    mac_vec_acc_if.slave bus
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int PW = 2 * DW;           // product width
    localparam int SW = PW + LW;          // lane-sum width
    localparam int XW = ACCW + 1;         // accumulate width incl. carry/sign guard

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                start_ok_s;
    logic                accept_s;
    logic                drain_r;
    logic [LENW-1:0]     len_r;
    logic [LENW-1:0]     cnt_r;
    logic                signed_r;
    logic                sat_r;
    logic                in_ready_r;
    logic                busy_r;
    logic                done_r;

    logic [LANES*PW-1:0] prod_s;
    logic [LANES*PW-1:0] prod_r;
    logic                v1_r;
    logic [XW-1:0]       sum_x_s;
    logic [SW-1:0]       sum_s;
    logic [SW-1:0]       sum_r;
    logic                v2_r;
    logic [XW-1:0]       acc_x_s;
    logic                ovf_add_s;
    logic [ACCW-1:0]     acc_s;
    logic [ACCW-1:0]     acc_r;
    logic                ovf_r;

    // Operand extension to product width, by mode.
    function automatic logic [PW-1:0] ext_op(input logic [DW-1:0] v, input logic sm);
        ext_op = {{DW{sm & v[DW-1]}}, v};
    endfunction

    // Product extension to accumulate width, by mode.
    function automatic logic [XW-1:0] ext_p(input logic [PW-1:0] v, input logic sm);
        ext_p = {{(XW-PW){sm & v[PW-1]}}, v};
    endfunction

    // Lane-sum extension to accumulate width, by mode.
    function automatic logic [XW-1:0] ext_s(input logic [SW-1:0] v, input logic sm);
        ext_s = {{(XW-SW){sm & v[SW-1]}}, v};
    endfunction

    // Next-state logic; start is only honoured in IDLE, so a busy job keeps its settings.
    always_comb begin
        state_s    = state_r;
        start_ok_s = 1'b0;
        accept_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    start_ok_s = 1'b1;
                    state_s    = (bus.len == {LENW{1'b0}}) ? DONE : ACCUM;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    accept_s = 1'b1;
                    state_s  = ((cnt_r + LENW'(1)) == len_r) ? DRAIN : ACCUM;
                end else begin
                    state_s = ACCUM;
                end
            end
            DRAIN: begin
                if (drain_r) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register, job settings, beat counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            drain_r    <= 1'b0;
            len_r      <= {LENW{1'b0}};
            cnt_r      <= {LENW{1'b0}};
            signed_r   <= 1'b0;
            sat_r      <= 1'b0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            drain_r    <= (state_r == DRAIN) && !drain_r;
            in_ready_r <= (state_s == ACCUM);
            busy_r     <= (state_s != IDLE);
            done_r     <= (state_s == DONE);
            if (start_ok_s) begin
                len_r    <= bus.len;
                signed_r <= bus.signed_mode;
                sat_r    <= bus.sat_en;
                cnt_r    <= {LENW{1'b0}};
            end else if (accept_s) begin
                cnt_r <= cnt_r + LENW'(1);
            end
        end
    end

    // Stage-1 products, one per lane, truncated to the exact product width.
    always_comb begin
        prod_s = {(LANES*PW){1'b0}};
        for (int k = 0; k < LANES; k++) begin
            prod_s[k*PW +: PW] = ext_op(bus.din_a[k*DW +: DW], signed_r)
                               * ext_op(bus.din_b[k*DW +: DW], signed_r);
        end
    end

    // Stage-2 lane sum; computed wide and trimmed, the true sum always fits SW bits.
    always_comb begin
        sum_x_s = {XW{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            sum_x_s = sum_x_s + ext_p(prod_r[k*PW +: PW], signed_r);
        end
        sum_s = sum_x_s[SW-1:0];
    end

    // Stage-3 add with one guard bit for overflow detection, then clamp or wrap.
    always_comb begin
        acc_x_s = {signed_r & acc_r[ACCW-1], acc_r} + ext_s(sum_r, signed_r);
        if (signed_r) begin
            ovf_add_s = acc_x_s[ACCW] ^ acc_x_s[ACCW-1];
        end else begin
            ovf_add_s = acc_x_s[ACCW];
        end
        if (ovf_add_s && sat_r) begin
            if (signed_r) begin
                acc_s = acc_x_s[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
            end else begin
                acc_s = {ACCW{1'b1}};
            end
        end else begin
            acc_s = acc_x_s[ACCW-1:0];
        end
    end

    // Pipeline registers and accumulator; a new job flushes everything to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_r <= {(LANES*PW){1'b0}};
            v1_r   <= 1'b0;
            sum_r  <= {SW{1'b0}};
            v2_r   <= 1'b0;
            acc_r  <= {ACCW{1'b0}};
            ovf_r  <= 1'b0;
        end else if (start_ok_s) begin
            prod_r <= {(LANES*PW){1'b0}};
            v1_r   <= 1'b0;
            sum_r  <= {SW{1'b0}};
            v2_r   <= 1'b0;
            acc_r  <= {ACCW{1'b0}};
            ovf_r  <= 1'b0;
        end else begin
            v1_r <= accept_s;
            v2_r <= v1_r;
            if (accept_s) begin
                prod_r <= prod_s;
            end
            if (v1_r) begin
                sum_r <= sum_s;
            end
            if (v2_r) begin
                acc_r <= acc_s;
                ovf_r <= ovf_r | ovf_add_s;
            end
        end
    end

    assign bus.in_ready = in_ready_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.dout     = acc_r;
    assign bus.overflow = ovf_r;
endmodule
